// File: rtl/load_data_aligner_pkg.sv
// rtl/load_data_aligner_pkg.sv - shared load-path constants, state type and legality helper
package load_data_aligner_pkg;

    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } load_state_t;

    // Undefined funct3 encodings and misaligned halfword/word accesses are both errors.
    function automatic logic load_illegal(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_LB, F3_LBU: load_illegal = 1'b0;
            F3_LH, F3_LHU: load_illegal = lane[0];
            F3_LW:         load_illegal = |lane;
            default:       load_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_lane_extend.sv
// rtl/load_lane_extend.sv - byte/halfword lane select with sign or zero extension
module load_lane_extend
    import load_data_aligner_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result,
    output logic        illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        illegal = load_illegal(funct3, lane);

        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        half_sel = lane[1] ? word[31:16] : word[15:0];

        result = '0;
        if (!illegal) begin
            case (funct3)
                F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
                F3_LH:   result = {{16{half_sel[15]}}, half_sel};
                F3_LW:   result = word;
                F3_LBU:  result = {24'd0, byte_sel};
                F3_LHU:  result = {16'd0, half_sel};
                default: result = '0;
            endcase
        end
    end

endmodule

// File: rtl/load_data_aligner.sv
// rtl/load_data_aligner.sv - load request to word read, lane extract/extend, result or error
// Optional WAIT-state timeout enabled by defining LOAD_TIMEOUT_EN.
module load_data_aligner
    import load_data_aligner_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    load_state_t       state_q;
    load_state_t       state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              accept;
    logic              take_rsp;
    logic              req_bad;
    logic              timeout_hit;
    logic [31:0]       ext_data;
    logic              ext_illegal;

    assign req_bad  = load_illegal(req_funct3, req_addr[1:0]);
    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

    load_lane_extend u_extend (
        .word    (mem_rsp_data),
        .lane    (addr_q[1:0]),
        .funct3  (funct3_q),
        .result  (ext_data),
        .illegal (ext_illegal)
    );

`ifdef LOAD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_ISSUE && mem_req_ready) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // A response in the final WAIT cycle takes priority over the timeout.
    assign timeout_hit = (state_q == ST_WAIT) && !mem_rsp_valid &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        rsp_valid     = 1'b0;
        busy          = 1'b1;
        accept        = 1'b0;
        take_rsp      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_bad ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    take_rsp = 1'b1;
                    state_d  = ST_RESP;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Result registers are written only on entry to RESP and hold until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            funct3_q <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                if (req_bad) begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end
            if (take_rsp) begin
                rsp_data <= ext_data;
                rsp_err  <= ext_illegal;
            end else if (timeout_hit) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_data_aligner.sv
// tb/tb_load_data_aligner.sv - table-driven check of load_data_aligner plus multi-cycle corner sequences
module tb_load_data_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_data_aligner #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_funct3    (req_funct3),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] word;
        int          rdy;
        int          rsp;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'hDEAD_BEEF;
    endtask

    // Issue one load and play a memory that stalls ready for rdy cycles and answers rsp cycles after the handshake.
    task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] word,
                           input int rdy, input int rsp,
                           output int lat, output logic [31:0] data, output logic err,
                           output logic saw_mem, output logic [31:0] maddr, output logic busy_ok);
        int   phase;
        int   cnt;
        logic got;
        lat = 0; data = '0; err = 1'b0; saw_mem = 1'b0; maddr = '0; busy_ok = 1'b1;
        phase = 0; cnt = 0; got = 1'b0;
        req_valid  = 1'b1;
        req_addr   = addr;
        req_funct3 = f3;
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 64 && !got; c++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'hDEAD_BEEF;
            if (!busy) busy_ok = 1'b0;
            if (rsp_valid) begin
                got  = 1'b1;
                lat  = c;
                data = rsp_data;
                err  = rsp_err;
            end else begin
                if (phase == 0 && mem_req_valid) begin
                    saw_mem = 1'b1;
                    maddr   = mem_addr;
                    if (cnt == rdy) begin
                        mem_req_ready = 1'b1;
                        phase = 1;
                        cnt   = 0;
                    end else begin
                        cnt++;
                    end
                end else if (phase == 1) begin
                    if (cnt == rsp) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data  = word;
                        phase = 2;
                    end else begin
                        cnt++;
                    end
                end
                step();
            end
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL load_timeout: no rsp_valid within 64 cycles for addr %h", addr);
        end
    endtask

    initial begin
        int          lat;
        int          n;
        logic [31:0] data;
        logic        err;
        logic        saw_mem;
        logic [31:0] maddr;
        logic        busy_ok;
        logic        seen;

        vecs[0]  = '{32'h0000_1003, 3'b000, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{32'h0000_1003, 3'b100, 32'h80FF_1234, 0, 0, 32'h0000_0080, 1'b0};
        vecs[2]  = '{32'h0000_1002, 3'b101, 32'h80FF_1234, 0, 0, 32'h0000_80FF, 1'b0};
        vecs[3]  = '{32'h0000_1000, 3'b001, 32'h0000_9ABC, 0, 0, 32'hFFFF_9ABC, 1'b0};
        vecs[4]  = '{32'h0000_1002, 3'b010, 32'h1111_2222, 0, 0, 32'h0000_0000, 1'b1};
        vecs[5]  = '{32'h0000_1000, 3'b011, 32'h1111_2222, 0, 0, 32'h0000_0000, 1'b1};
        vecs[6]  = '{32'h0000_2000, 3'b010, 32'h1357_9BDF, 4, 4, 32'h1357_9BDF, 1'b0};
        vecs[7]  = '{32'h0000_1001, 3'b100, 32'h1234_5678, 0, 0, 32'h0000_0056, 1'b0};
        vecs[8]  = '{32'h0000_1001, 3'b001, 32'h1234_5678, 0, 0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{32'h0000_1000, 3'b101, 32'h0000_8001, 1, 0, 32'h0000_8001, 1'b0};
        vecs[10] = '{32'h0000_1000, 3'b000, 32'h0000_00F0, 0, 2, 32'hFFFF_FFF0, 1'b0};
        vecs[11] = '{32'h0000_1004, 3'b110, 32'h1111_2222, 0, 0, 32'h0000_0000, 1'b1};
        vecs[12] = '{32'h0000_1002, 3'b001, 32'hFEDC_0000, 0, 0, 32'hFFFF_FEDC, 1'b0};
        vecs[13] = '{32'h0000_1003, 3'b111, 32'h1111_2222, 0, 0, 32'h0000_0000, 1'b1};
        vecs[14] = '{32'h0000_1002, 3'b100, 32'h00AB_0000, 0, 0, 32'h0000_00AB, 1'b0};
        vecs[15] = '{32'h0000_3004, 3'b010, 32'hCAFE_F00D, 1, 2, 32'hCAFE_F00D, 1'b0};

        rst_n      = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        idle_inputs();
        step();
        step();
        check("reset_req_ready", req_ready, 1);
        check("reset_mem_req_valid", mem_req_valid, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data", rsp_data, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("v%0d_req_ready", i), req_ready, 1);
            do_load(vecs[i].addr, vecs[i].f3, vecs[i].word, vecs[i].rdy, vecs[i].rsp,
                    lat, data, err, saw_mem, maddr, busy_ok);
            check($sformatf("v%0d_latency", i), lat,
                  vecs[i].exp_err ? 1 : 3 + vecs[i].rdy + vecs[i].rsp);
            check($sformatf("v%0d_rsp_data", i), data, vecs[i].exp_data);
            check($sformatf("v%0d_rsp_err", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_mem_req_seen", i), saw_mem, !vecs[i].exp_err);
            if (saw_mem)
                check($sformatf("v%0d_mem_addr", i), maddr, vecs[i].addr & 32'hFFFF_FFFC);
            check($sformatf("v%0d_busy", i), busy_ok, 1);
            step();
            check($sformatf("v%0d_rsp_pulse_end", i), rsp_valid, 0);
            check($sformatf("v%0d_back_to_back_ready", i), req_ready, 1);
            check($sformatf("v%0d_rsp_data_hold", i), rsp_data, vecs[i].exp_data);
        end

        // Reset during WAIT aborts the load; a late response must be ignored.
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_funct3 = 3'b010;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check("abort_in_wait_busy", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h5555_AAAA;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid) seen = 1'b1;
            step();
            mem_rsp_valid = 1'b0;
        end
        check("abort_no_rsp_valid", seen, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_rsp_data", rsp_data, 0);

`ifdef LOAD_TIMEOUT_EN
        // No response: error after 8 WAIT cycles, a response in the RESP cycle is dropped.
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_funct3 = 3'b010;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            n++;
            step();
        end
        check("timeout_wait_cycles", n, 8);
        check("timeout_rsp_valid", rsp_valid, 1);
        check("timeout_rsp_err", rsp_err, 1);
        check("timeout_rsp_data", rsp_data, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h7777_8888;
        step();
        mem_rsp_valid = 1'b0;
        check("timeout_late_rsp_valid", rsp_valid, 0);
        check("timeout_late_req_ready", req_ready, 1);
        check("timeout_late_rsp_err_hold", rsp_err, 1);
        step();
        check("timeout_late_no_pulse", rsp_valid, 0);

        // Response in the final WAIT cycle wins over the timeout.
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_funct3 = 3'b010;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int c = 0; c < 7; c++) step();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0BAD_F00D;
        step();
        mem_rsp_valid = 1'b0;
        check("tie_rsp_valid", rsp_valid, 1);
        check("tie_rsp_err", rsp_err, 0);
        check("tie_rsp_data", rsp_data, 32'h0BAD_F00D);
        step();
`else
        // Without the timeout, WAIT holds until the memory answers.
        req_valid = 1'b1; req_addr = 32'h0000_2000; req_funct3 = 3'b010;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        seen = 1'b0;
        busy_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) seen = 1'b1;
            if (!busy) busy_ok = 1'b0;
            step();
        end
        check("hold_no_rsp_valid", seen, 0);
        check("hold_busy", busy_ok, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h2468_ACE0;
        step();
        mem_rsp_valid = 1'b0;
        check("hold_rsp_valid", rsp_valid, 1);
        check("hold_rsp_err", rsp_err, 0);
        check("hold_rsp_data", rsp_data, 32'h2468_ACE0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
